// File: rtl/ultrasonic_scheduler_if.sv
// Signal bundle between the ultrasonic scheduler and its user: sensor pins,
// the run enable and the published measurement results.
interface ultrasonic_scheduler_if #(
    parameter int unsigned NUM_SENSORS = 4
);
    logic                   enable;
    logic [NUM_SENSORS-1:0] echo;
    logic [NUM_SENSORS-1:0] trigger;
    logic                   result_valid;
    logic [2:0]             result_id;
    logic [21:0]            echo_cycles;
    logic                   timeout;
    logic [NUM_SENSORS-1:0] object_detected;
    logic                   busy;

    modport master (
        output enable, echo,
        input  trigger, result_valid, result_id, echo_cycles, timeout, object_detected, busy
    );

    modport slave (
        input  enable, echo,
        output trigger, result_valid, result_id, echo_cycles, timeout, object_detected, busy
    );
endinterface

// File: rtl/ultrasonic_scheduler.sv
// Round-robin ultrasonic sensor sequencer: one sensor pings at a time, its echo
// is timed against a window limit and the width plus a near flag is published.
module ultrasonic_scheduler #(
    parameter int unsigned CLOCK_FREQ     = 50000000,
    parameter int unsigned NUM_SENSORS    = 4,
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned GAP_CYCLES     = 500000,
    parameter int unsigned THRESH_CYCLES  = 29154
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ultrasonic_scheduler_if.slave   bus
);
    localparam int unsigned IDXW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;

    if (NUM_SENSORS < 1 || NUM_SENSORS > 8) begin : g_bad_num_sensors
        $error("ultrasonic_scheduler: NUM_SENSORS must be 1..8");
    end
    if (CLOCK_FREQ == 0) begin : g_bad_clock_freq
        $error("ultrasonic_scheduler: CLOCK_FREQ must be non-zero");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        REPORT    = 3'd4,
        GAP       = 3'd5
    } state_e;

    state_e                 state_q;
    logic [IDXW-1:0]        idx_q;
    logic [NUM_SENSORS-1:0] echo_s1_q;
    logic [NUM_SENSORS-1:0] echo_s2_q;
    logic [NUM_SENSORS-1:0] trigger_q;
    logic [NUM_SENSORS-1:0] object_q;
    logic [31:0]            cnt_q;
    logic [31:0]            win_q;
    logic [21:0]            width_q;
    logic                   result_valid_q;
    logic [2:0]             result_id_q;
    logic [21:0]            echo_cycles_q;
    logic                   timeout_q;
    logic                   busy_q;

    logic                   echo_sel_s;
    logic [21:0]            width_inc_d;
    logic [IDXW-1:0]        idx_d;

    function automatic logic [NUM_SENSORS-1:0] onehot(input logic [IDXW-1:0] i);
        logic [NUM_SENSORS-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Selected synchronized echo, saturating width increment and next sensor index.
    always_comb begin
        echo_sel_s  = echo_s2_q[idx_q];
        width_inc_d = width_q;
        idx_d       = idx_q;
        if (width_q != 22'h3FFFFE) begin
            width_inc_d = width_q + 22'd1;
        end else begin
            width_inc_d = width_q;
        end
        if (idx_q == IDXW'(NUM_SENSORS - 1)) begin
            idx_d = '0;
        end else begin
            idx_d = idx_q + IDXW'(1);
        end
    end

    // Echo synchronizer plus the slot FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            echo_s1_q      <= '0;
            echo_s2_q      <= '0;
            trigger_q      <= '0;
            object_q       <= '0;
            cnt_q          <= 32'd0;
            win_q          <= 32'd0;
            width_q        <= 22'd0;
            result_valid_q <= 1'b0;
            result_id_q    <= 3'd0;
            echo_cycles_q  <= 22'd0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            echo_s1_q <= bus.echo;
            echo_s2_q <= echo_s1_q;
            case (state_q)
                IDLE: begin
                    if (bus.enable) begin
                        state_q   <= TRIG;
                        trigger_q <= onehot(idx_q);
                        cnt_q     <= 32'd0;
                        busy_q    <= 1'b1;
                    end else begin
                        busy_q    <= 1'b0;
                    end
                end
                TRIG: begin
                    if (cnt_q == 32'(TRIG_CYCLES - 1)) begin
                        trigger_q <= '0;
                        win_q     <= 32'd0;
                        state_q   <= WAIT_RISE;
                    end else begin
                        cnt_q     <= cnt_q + 32'd1;
                    end
                end
                WAIT_RISE: begin
                    if (win_q == 32'(TIMEOUT_CYCLES - 1)) begin
                        state_q         <= REPORT;
                        result_valid_q  <= 1'b1;
                        result_id_q     <= 3'(idx_q);
                        echo_cycles_q   <= 22'h3FFFFF;
                        timeout_q       <= 1'b1;
                        object_q[idx_q] <= 1'b0;
                    end else begin
                        win_q <= win_q + 32'd1;
                        if (echo_sel_s) begin
                            state_q <= MEASURE;
                            width_q <= 22'd0;
                        end
                    end
                end
                MEASURE: begin
                    // The falling-edge cycle is counted so a W-cycle echo reports W.
                    if (win_q == 32'(TIMEOUT_CYCLES - 1)) begin
                        state_q         <= REPORT;
                        result_valid_q  <= 1'b1;
                        result_id_q     <= 3'(idx_q);
                        echo_cycles_q   <= 22'h3FFFFF;
                        timeout_q       <= 1'b1;
                        object_q[idx_q] <= 1'b0;
                    end else if (!echo_sel_s) begin
                        state_q         <= REPORT;
                        result_valid_q  <= 1'b1;
                        result_id_q     <= 3'(idx_q);
                        echo_cycles_q   <= width_inc_d;
                        timeout_q       <= 1'b0;
                        object_q[idx_q] <= (width_inc_d < 22'(THRESH_CYCLES));
                    end else begin
                        width_q <= width_inc_d;
                        win_q   <= win_q + 32'd1;
                    end
                end
                REPORT: begin
                    result_valid_q <= 1'b0;
                    cnt_q          <= 32'd0;
                    state_q        <= GAP;
                end
                GAP: begin
                    if (cnt_q == 32'(GAP_CYCLES - 1)) begin
                        idx_q <= idx_d;
                        cnt_q <= 32'd0;
                        if (bus.enable) begin
                            state_q   <= TRIG;
                            trigger_q <= onehot(idx_d);
                        end else begin
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    trigger_q      <= '0;
                    result_valid_q <= 1'b0;
                    busy_q         <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trigger         = trigger_q;
    assign bus.result_valid    = result_valid_q;
    assign bus.result_id       = result_id_q;
    assign bus.echo_cycles     = echo_cycles_q;
    assign bus.timeout         = timeout_q;
    assign bus.object_detected = object_q;
    assign bus.busy            = busy_q;
endmodule
